macc_stream_sat: RTL and testbench

//  Streaming signed multiply-accumulate: generalises the single-channel accumulator with

---
 rtl/macc_stream_sat.sv | 159 +++++++++++++++
 tb/tb_macc_stream_sat.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_stream_sat.sv
// Streaming signed multiply-accumulate: one dot product per framed operand stream,
// 3-stage pipeline with valid/ready handshakes and optional saturation.
module macc_stream_sat #(
  parameter int SIZEIN   = 16,
  parameter int SIZEOUT  = 40,
  parameter bit SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [SIZEIN-1:0]  a,
  input  logic [SIZEIN-1:0]  b,
  output logic               in_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [SIZEOUT-1:0] accum_out,
  output logic               out_ovf
);

  localparam int PW = 2 * SIZEIN;
  localparam logic signed [SIZEOUT-1:0] ACC_MAX = {1'b0, {(SIZEOUT-1){1'b1}}};
  localparam logic signed [SIZEOUT-1:0] ACC_MIN = {1'b1, {(SIZEOUT-1){1'b0}}};

  logic signed [SIZEIN-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic                      s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic                      s1_valid_q, s1_valid_d;
  logic signed [SIZEOUT-1:0] s2_prod_q, s2_prod_d;
  logic                      s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic                      s2_valid_q, s2_valid_d;
  logic signed [SIZEOUT-1:0] acc_q, acc_d;
  logic                      ovf_frame_q, ovf_frame_d;
  logic [SIZEOUT-1:0]        accum_out_q, accum_out_d;
  logic                      out_ovf_q, out_ovf_d;
  logic                      out_valid_q, out_valid_d;

  logic                      stall_s;
  logic                      adv_s;
  logic signed [PW-1:0]      prod_s;
  logic signed [SIZEOUT-1:0] base_s;
  logic signed [SIZEOUT:0]   sum_s;
  logic                      ovf_s;
  logic signed [SIZEOUT-1:0] acc_next_s;
  logic                      ovf_frame_next_s;

  // A finished frame may not overwrite a result the consumer has not taken yet.
  assign stall_s   = out_valid_q & ~out_ready & s2_valid_q & s2_last_q;
  assign adv_s     = ce & ~stall_s & rst_n;
  assign in_ready  = adv_s;
  assign out_valid = out_valid_q;
  assign accum_out = accum_out_q;
  assign out_ovf   = out_ovf_q;

  // Next-state for pipeline stages, accumulator and output register.
  always_comb begin
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_valid_d  = s1_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    s2_valid_d  = s2_valid_q;
    acc_d       = acc_q;
    ovf_frame_d = ovf_frame_q;
    accum_out_d = accum_out_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    prod_s = PW'(s1_a_q) * PW'(s1_b_q);
    if (s2_first_q) begin
      base_s = '0;
    end else begin
      base_s = acc_q;
    end
    sum_s = (SIZEOUT + 1)'(base_s) + (SIZEOUT + 1)'(s2_prod_q);
    ovf_s = sum_s[SIZEOUT] ^ sum_s[SIZEOUT-1];
    if (ovf_s && SATURATE) begin
      acc_next_s = sum_s[SIZEOUT] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next_s = sum_s[SIZEOUT-1:0];
    end
    ovf_frame_next_s = (s2_first_q ? 1'b0 : ovf_frame_q) | ovf_s;

    if (adv_s) begin
      s1_a_d     = a;
      s1_b_d     = b;
      s1_first_d = in_first;
      s1_last_d  = in_last;
      s1_valid_d = in_valid;
      s2_prod_d  = SIZEOUT'(prod_s);
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_valid_d = s1_valid_q;
      if (s2_valid_q) begin
        acc_d       = acc_next_s;
        ovf_frame_d = ovf_frame_next_s;
        if (s2_last_q) begin
          accum_out_d = acc_next_s;
          out_ovf_d   = ovf_frame_next_s;
        end else begin
          accum_out_d = accum_out_q;
        end
      end else begin
        acc_d = acc_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // A new result loading on the same edge as a consume keeps out_valid high.
    if (adv_s && s2_valid_q && s2_last_q) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      acc_q       <= '0;
      ovf_frame_q <= 1'b0;
      accum_out_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_valid_q  <= s1_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_valid_q  <= s2_valid_d;
      acc_q       <= acc_d;
      ovf_frame_q <= ovf_frame_d;
      accum_out_q <= accum_out_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_macc_stream_sat.sv
// Directed bench for macc_stream_sat: a 40-bit saturating instance plus 32-bit
// saturating and wrapping instances sharing the same stimulus.
module tb_macc_stream_sat;

  logic               clk = 1'b0;
  logic               rst_n, ce, in_valid, in_first, in_last, out_ready;
  logic signed [15:0] a, b;
  logic               in_ready_m, out_valid_m, ovf_m;
  logic [39:0]        accum_m;
  logic               in_ready_s, out_valid_s, ovf_s;
  logic [31:0]        accum_s;
  logic               in_ready_w, out_valid_w, ovf_w;
  logic [31:0]        accum_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcount = 0;
  logic [39:0] qm_v[$], qs_v[$], qw_v[$];
  logic        qm_o[$], qs_o[$], qw_o[$];
  int          qm_c[$];

  macc_stream_sat #(.SIZEIN(16), .SIZEOUT(40), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .in_ready(in_ready_m), .out_ready(out_ready),
    .out_valid(out_valid_m), .accum_out(accum_m), .out_ovf(ovf_m));

  macc_stream_sat #(.SIZEIN(16), .SIZEOUT(32), .SATURATE(1'b1)) dut_s32 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .in_ready(in_ready_s), .out_ready(out_ready),
    .out_valid(out_valid_s), .accum_out(accum_s), .out_ovf(ovf_s));

  macc_stream_sat #(.SIZEIN(16), .SIZEOUT(32), .SATURATE(1'b0)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .in_ready(in_ready_w), .out_ready(out_ready),
    .out_valid(out_valid_w), .accum_out(accum_w), .out_ovf(ovf_w));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Results are logged half a cycle after the edge; a transfer completes on the next edge.
  always @(negedge clk) begin
    if (out_valid_m) vcount <= vcount + 1;
    if (out_valid_m && out_ready) begin
      qm_v.push_back(accum_m); qm_o.push_back(ovf_m); qm_c.push_back(cyc);
    end
    if (out_valid_s && out_ready) begin
      qs_v.push_back({8'h00, accum_s}); qs_o.push_back(ovf_s);
    end
    if (out_valid_w && out_ready) begin
      qw_v.push_back({8'h00, accum_w}); qw_o.push_back(ovf_w);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic clear();
    qm_v.delete(); qm_o.delete(); qm_c.delete();
    qs_v.delete(); qs_o.delete(); qw_v.delete(); qw_o.delete();
    vcount = 0;
  endtask

  task automatic pad();
    while (qm_v.size() < 2) begin qm_v.push_back('x); qm_o.push_back(1'bx); qm_c.push_back(-1); end
    while (qs_v.size() < 2) begin qs_v.push_back('x); qs_o.push_back(1'bx); end
    while (qw_v.size() < 2) begin qw_v.push_back('x); qw_o.push_back(1'bx); end
  endtask

  // Presents one sample from just after an edge and returns the edge number it was accepted on.
  task automatic send(input logic signed [15:0] av, input logic signed [15:0] bv,
                      input logic f, input logic l, output int acc_cyc);
    a = av; b = bv; in_first = f; in_last = l; in_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 40 && acc_cyc < 0; i++) begin
      @(negedge clk);
      if (in_ready_m) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    if (acc_cyc < 0) begin
      checks++; errors++;
      $display("FAIL send_timeout: sample a=%0d not accepted within 40 cycles", av);
    end
  endtask

  task automatic frame70(output int first_e, output int last_e);
    int e;
    send(16'sd1, 16'sd5, 1'b1, 1'b0, first_e);
    send(16'sd2, 16'sd6, 1'b0, 1'b0, e);
    send(16'sd3, 16'sd7, 1'b0, 1'b0, e);
    send(16'sd4, 16'sd8, 1'b0, 1'b1, last_e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; a = '0; b = '0;
    repeat (2) step();
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_m); end
    checks++; if (accum_m !== 40'h0) begin errors++; $display("FAIL reset_accum got %0h exp 0", accum_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_m); end
    checks++; if (in_ready_m !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready_m); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready_m); end
  endtask

  task automatic test_basic();
    int f, l;
    clear();
    frame70(f, l);
    idle(5);
    checks++; if (qm_v.size() !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", qm_v.size()); end
    pad();
    checks++; if (qm_v[0] !== 40'd70) begin errors++; $display("FAIL basic_value got %0d exp 70", qm_v[0]); end
    checks++; if (qm_o[0] !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", qm_o[0]); end
    checks++; if (qm_c[0] !== l + 2) begin errors++; $display("FAIL basic_latency got %0d exp %0d", qm_c[0], l + 2); end
    checks++; if (vcount !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d exp 1", vcount); end
    checks++; if (qs_v[0] !== 40'd70) begin errors++; $display("FAIL basic_value_s32 got %0d exp 70", qs_v[0]); end
  endtask

  task automatic test_back_to_back();
    int f, l, l2;
    clear();
    frame70(f, l);
    send(-16'sd3, 16'sd7, 1'b1, 1'b1, l2);
    idle(5);
    checks++; if (l2 !== l + 1) begin errors++; $display("FAIL b2b_accept got %0d exp %0d", l2, l + 1); end
    checks++; if (qm_v.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", qm_v.size()); end
    pad();
    checks++; if (qm_v[0] !== 40'd70) begin errors++; $display("FAIL b2b_first got %0h exp 46", qm_v[0]); end
    checks++; if (qm_v[1] !== 40'hFF_FFFF_FFEB) begin errors++; $display("FAIL b2b_second got %0h exp ffffffffeb", qm_v[1]); end
    checks++; if (qm_c[1] !== qm_c[0] + 1) begin errors++; $display("FAIL b2b_gap got %0d exp %0d", qm_c[1], qm_c[0] + 1); end
    checks++; if (vcount !== 2) begin errors++; $display("FAIL b2b_valid_cycles got %0d exp 2", vcount); end
  endtask

  task automatic test_saturate();
    int e;
    clear();
    send(-16'sd32768, -16'sd32768, 1'b1, 1'b0, e);
    send(-16'sd32768, -16'sd32768, 1'b0, 1'b0, e);
    send(-16'sd32768, -16'sd32768, 1'b0, 1'b1, e);
    send(16'sd1, 16'sd1, 1'b1, 1'b1, e);
    idle(5);
    checks++; if (qs_v.size() !== 2) begin errors++; $display("FAIL sat_count got %0d exp 2", qs_v.size()); end
    pad();
    checks++; if (qs_v[0] !== 40'h00_7FFF_FFFF) begin errors++; $display("FAIL sat_value got %0h exp 7fffffff", qs_v[0]); end
    checks++; if (qs_o[0] !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b exp 1", qs_o[0]); end
    checks++; if (qw_v[0] !== 40'h00_C000_0000) begin errors++; $display("FAIL wrap_value got %0h exp c0000000", qw_v[0]); end
    checks++; if (qw_o[0] !== 1'b1) begin errors++; $display("FAIL wrap_ovf got %b exp 1", qw_o[0]); end
    checks++; if (qs_v[1] !== 40'd1) begin errors++; $display("FAIL sat_next_value got %0h exp 1", qs_v[1]); end
    checks++; if (qs_o[1] !== 1'b0) begin errors++; $display("FAIL sat_next_ovf got %b exp 0", qs_o[1]); end
    checks++; if (qw_v[1] !== 40'd1) begin errors++; $display("FAIL wrap_next_value got %0h exp 1", qw_v[1]); end
    checks++; if (qw_o[1] !== 1'b0) begin errors++; $display("FAIL wrap_next_ovf got %b exp 0", qw_o[1]); end
    checks++; if (qm_v[0] !== 40'h00_C000_0000) begin errors++; $display("FAIL wide_value got %0h exp c0000000", qm_v[0]); end
    checks++; if (qm_o[0] !== 1'b0) begin errors++; $display("FAIL wide_ovf got %b exp 0", qm_o[0]); end
  endtask

  task automatic test_stall();
    int f, l, l2;
    clear();
    out_ready = 1'b0;
    frame70(f, l);
    send(-16'sd3, 16'sd7, 1'b1, 1'b1, l2);
    step();
    checks++; if (in_ready_m !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready_m); end
    checks++; if (out_valid_m !== 1'b1) begin errors++; $display("FAIL stall_out_valid got %b exp 1", out_valid_m); end
    repeat (3) step();
    checks++; if (accum_m !== 40'd70) begin errors++; $display("FAIL stall_hold got %0d exp 70", accum_m); end
    checks++; if (in_ready_m !== 1'b0) begin errors++; $display("FAIL stall_hold_in_ready got %b exp 0", in_ready_m); end
    out_ready = 1'b1;
    idle(5);
    checks++; if (qm_v.size() !== 2) begin errors++; $display("FAIL stall_count got %0d exp 2", qm_v.size()); end
    pad();
    checks++; if (qm_v[0] !== 40'd70) begin errors++; $display("FAIL stall_first got %0h exp 46", qm_v[0]); end
    checks++; if (qm_v[1] !== 40'hFF_FFFF_FFEB) begin errors++; $display("FAIL stall_second got %0h exp ffffffffeb", qm_v[1]); end
    checks++; if (qm_c[1] !== qm_c[0] + 1) begin errors++; $display("FAIL stall_order got %0d exp %0d", qm_c[1], qm_c[0] + 1); end
  endtask

  task automatic test_ce();
    int f, e, l;
    clear();
    send(16'sd1, 16'sd5, 1'b1, 1'b0, f);
    send(16'sd2, 16'sd6, 1'b0, 1'b0, e);
    for (int i = 0; i < 5; i++) begin
      ce = 1'b0; in_valid = i[0]; a = 16'sd99; b = 16'sd99; in_first = 1'b1; in_last = 1'b1;
      @(negedge clk);
      checks++; if (in_ready_m !== 1'b0) begin errors++; $display("FAIL ce_in_ready got %b exp 0", in_ready_m); end
      @(posedge clk); #1;
    end
    ce = 1'b1; in_valid = 1'b0;
    send(16'sd3, 16'sd7, 1'b0, 1'b0, e);
    send(16'sd4, 16'sd8, 1'b0, 1'b1, l);
    idle(5);
    checks++; if (qm_v.size() !== 1) begin errors++; $display("FAIL ce_count got %0d exp 1", qm_v.size()); end
    pad();
    checks++; if (qm_v[0] !== 40'd70) begin errors++; $display("FAIL ce_value got %0d exp 70", qm_v[0]); end
    checks++; if (qm_c[0] !== f + 10) begin errors++; $display("FAIL ce_latency got %0d exp %0d", qm_c[0], f + 10); end
  endtask

  task automatic test_reset_mid();
    int f, l, e;
    clear();
    out_ready = 1'b0;
    frame70(f, l);
    idle(4);
    checks++; if (out_valid_m !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", out_valid_m); end
    send(16'sd10, 16'sd10, 1'b1, 1'b0, e);
    send(16'sd10, 16'sd10, 1'b0, 1'b0, e);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", out_valid_m); end
    checks++; if (accum_m !== 40'h0) begin errors++; $display("FAIL midreset_accum got %0h exp 0", accum_m); end
    checks++; if (in_ready_m !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got %b exp 0", in_ready_m); end
    step(); step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    clear();
    frame70(f, l);
    idle(5);
    checks++; if (qm_v.size() !== 1) begin errors++; $display("FAIL after_reset_count got %0d exp 1", qm_v.size()); end
    pad();
    checks++; if (qm_v[0] !== 40'd70) begin errors++; $display("FAIL after_reset_value got %0d exp 70", qm_v[0]); end
    checks++; if (qm_o[0] !== 1'b0) begin errors++; $display("FAIL after_reset_ovf got %b exp 0", qm_o[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturate();
    test_stall();
    test_ce();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
